encoder_4x2_seq: RTL and testbench

//  Registered 4-to-2 priority encoder with sticky request capture and a

---
 rtl/encoder_4x2_seq.sv | 108 ++++++++++
 tb/tb_encoder_4x2_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_4x2_seq.sv
// Registered 4-to-2 priority encoder: sticky request capture into a pending
// register, code presented on {a,b} behind a valid/ready handshake.
module encoder_4x2_seq #(
  parameter bit EDGE_MODE  = 1'b1,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic [3:0] pending,
  output logic       overrun
);

  logic [3:0] d_in;
  logic [3:0] d_prev_q, d_prev_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] set_vec, clr_vec, lost_vec;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic [1:0] winner;
  logic       any_pending;
  logic       load;

  assign d_in = {d3, d2, d1, d0};

  // d_prev only matters in edge mode; in level mode it is kept at zero so
  // every high input counts as a request.
  assign d_prev_d = EDGE_MODE ? d_in : 4'b0000;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign set_vec[gi]   = d_in[gi] & ~(d_prev_q[gi] & EDGE_MODE);
      // A new event on a bit that is still pending and not being served now is lost.
      assign lost_vec[gi]  = EDGE_MODE & set_vec[gi] & pending_q[gi] & ~clr_vec[gi];
      assign pending_d[gi] = (pending_q[gi] | set_vec[gi]) & ~(clr_vec[gi] & ~set_vec[gi]);
    end
  endgenerate

  // Winner is taken from the registered pending bits, never the raw inputs.
  always_comb begin
    winner = 2'b00;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 4; i++) begin
        if (pending_q[i]) winner = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (pending_q[i]) winner = 2'(i);
      end
    end
  end

  assign any_pending = |pending_q;
  assign load        = (~valid_q | ready) & any_pending;

  always_comb begin
    clr_vec = 4'b0000;
    if (load) clr_vec = 4'b0001 << winner;
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    valid_d   = valid_q;
    overrun_d = overrun_q | (|lost_vec);
    if (load) begin
      {a_d, b_d} = winner;
      valid_d    = 1'b1;
    end else if (valid_q & ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_prev_q  <= 4'b0000;
      pending_q <= 4'b0000;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      d_prev_q  <= d_prev_d;
      pending_q <= pending_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Bench for encoder_4x2_seq: four parameter variants share stimulus and are
// each checked against a request-list reference model every cycle.
module tb_encoder_4x2_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic       ready;

  logic       a_o     [4];
  logic       b_o     [4];
  logic       valid_o [4];
  logic [3:0] pend_o  [4];
  logic       ovr_o   [4];

  // Instance k parameters: edge mode and priority direction
  localparam bit EDGE_K [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit HIGH_K [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  encoder_4x2_seq #(.EDGE_MODE(1'b1), .HIGH_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .ready(ready),
    .a(a_o[0]), .b(b_o[0]), .valid(valid_o[0]), .pending(pend_o[0]), .overrun(ovr_o[0]));
  encoder_4x2_seq #(.EDGE_MODE(1'b0), .HIGH_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .ready(ready),
    .a(a_o[1]), .b(b_o[1]), .valid(valid_o[1]), .pending(pend_o[1]), .overrun(ovr_o[1]));
  encoder_4x2_seq #(.EDGE_MODE(1'b0), .HIGH_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .ready(ready),
    .a(a_o[2]), .b(b_o[2]), .valid(valid_o[2]), .pending(pend_o[2]), .overrun(ovr_o[2]));
  encoder_4x2_seq #(.EDGE_MODE(1'b1), .HIGH_FIRST(1'b0)) u3 (
    .clk(clk), .rst(rst), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .ready(ready),
    .a(a_o[3]), .b(b_o[3]), .valid(valid_o[3]), .pending(pend_o[3]), .overrun(ovr_o[3]));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state per instance: set of outstanding requests, presented code
  bit [3:0] m_pend  [4];
  bit [3:0] m_prev  [4];
  bit [1:0] m_code  [4];
  bit       m_valid [4];
  bit       m_ovr   [4];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_pend[k] = '0; m_prev[k] = '0; m_code[k] = '0; m_valid[k] = 0; m_ovr[k] = 0;
    end
  endtask

  function automatic int pick(input bit [3:0] reqs, input bit high_first);
    int w = -1;
    for (int n = 0; n < 4; n++) begin
      int idx = high_first ? 3 - n : n;
      if (w < 0 && reqs[idx]) w = idx;
    end
    return w;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int served = -1;
      if ((!m_valid[k] || ready) && m_pend[k] != 0) served = pick(m_pend[k], HIGH_K[k]);
      for (int i = 0; i < 4; i++) begin
        bit ev = EDGE_K[k] ? (d[i] && !m_prev[k][i]) : d[i];
        if (ev) begin
          if (EDGE_K[k] && m_pend[k][i] && served != i) m_ovr[k] = 1;
          m_pend[k][i] = 1;
        end else if (served == i) begin
          m_pend[k][i] = 0;
        end
      end
      if (served >= 0) begin
        m_code[k]  = 2'(served);
        m_valid[k] = 1;
      end else if (m_valid[k] && ready) begin
        m_valid[k] = 0;
      end
      m_prev[k] = d;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d_a", k), {3'b000, a_o[k]}, {3'b000, m_code[k][1]});
      chk($sformatf("u%0d_b", k), {3'b000, b_o[k]}, {3'b000, m_code[k][0]});
      chk($sformatf("u%0d_valid", k), {3'b000, valid_o[k]}, {3'b000, m_valid[k]});
      chk($sformatf("u%0d_pending", k), pend_o[k], m_pend[k]);
      chk($sformatf("u%0d_overrun", k), {3'b000, ovr_o[k]}, {3'b000, m_ovr[k]});
    end
  endtask

  // One clock: model advances on the edge, outputs sampled 1 ns later
  task automatic cycle(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      $display("t=%0t d=%b ready=%b u0: code=%b%b valid=%b pend=%b ovr=%b",
               $time, d, ready, a_o[0], b_o[0], valid_o[0], pend_o[0], ovr_o[0]);
    end
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; d = '0; ready = 1'b1;
    @(posedge clk); #1;
    async_reset();
    chk("reset_valid", {3'b000, valid_o[0]}, 4'b0000);
    chk("reset_pending", pend_o[0], 4'b0000);

    // Single d2 pulse
    d = 4'b0100; cycle();
    chk("t1_pend", pend_o[0], 4'b0100);
    d = 4'b0000; cycle();
    chk("t1_code", {2'b00, a_o[0], b_o[0]}, 4'b0010);
    chk("t1_valid", {3'b000, valid_o[0]}, 4'b0001);
    cycle();
    chk("t1_drain", {3'b000, valid_o[0]}, 4'b0000);

    // d0,d1,d3 together, free-flowing consumer
    d = 4'b1011; cycle(); d = 4'b0000; cycle();
    chk("t2_first", {2'b00, a_o[0], b_o[0]}, 4'b0011);
    cycle(3);

    // Same burst with the consumer stalled for 5 cycles
    ready = 1'b0; d = 4'b1011; cycle(); d = 4'b0000; cycle(5);
    chk("t3_hold_code", {2'b00, a_o[0], b_o[0]}, 4'b0011);
    chk("t3_hold_pend", pend_o[0], 4'b0011);
    ready = 1'b1; cycle(3);

    // Repeat event on an already pending bit
    async_reset();
    ready = 1'b0;
    d = 4'b1000; cycle(); d = 4'b0000; cycle();
    d = 4'b0010; cycle(); d = 4'b0000; cycle();
    d = 4'b0010; cycle(); d = 4'b0000; cycle();
    chk("t4_overrun", {3'b000, ovr_o[0]}, 4'b0001);
    chk("t4_pend", pend_o[0], 4'b0010);
    ready = 1'b1; cycle(4);
    chk("t4_sticky", {3'b000, ovr_o[0]}, 4'b0001);

    // Held inputs: level-mode re-pending and priority direction
    async_reset();
    d = 4'b0001; cycle(6);
    d = 4'b1001; cycle(6);
    d = 4'b0000; cycle(3);

    // Reset while busy, with d1 held across the release
    ready = 1'b0; d = 4'b1000; cycle(); d = 4'b0110; cycle(); d = 4'b0010; cycle();
    async_reset();
    chk("t6_valid", {3'b000, valid_o[0]}, 4'b0000);
    ready = 1'b1; cycle(3);

    // Randomized traffic with occasional resets
    for (int r = 0; r < 400; r++) begin
      d     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
